// File: rtl/axi4lite_mem_slave.sv
// rtl/axi4lite_mem_slave.sv - AXI4-Lite memory slave with independent read/write FSMs
module axi4lite_mem_slave #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 0,
  parameter int WRITE_LATENCY = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0] RLAT = 4'(READ_LATENCY);
  localparam logic [3:0] WLAT = 4'(WRITE_LATENCY);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < DEPTH_W;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             unused_addr_bits;
  assign aw_idx = awaddr[ADDR_WIDTH-1:OFF_W];
  assign ar_idx = araddr[ADDR_WIDTH-1:OFF_W];
  assign unused_addr_bits = &{1'b0, awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

  // Read channel
  r_state_t         r_state;
  logic [IDX_W-1:0] rd_idx, r_src_idx;
  logic [3:0]       r_cnt;
  logic             r_ok;
  logic [DATA_WIDTH-1:0] r_word;

  assign r_src_idx = (r_state == R_IDLE) ? ar_idx : rd_idx;
  assign r_ok      = in_range(r_src_idx);
  assign r_word    = r_ok ? mem[r_src_idx[MEM_AW-1:0]] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      rd_idx  <= '0;
      r_cnt   <= '0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          rd_idx  <= ar_idx;
          arready <= 1'b0;
          if (RLAT == 4'd0) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rdata   <= r_word;
            rresp   <= r_ok ? OKAY : SLVERR;
          end else begin
            r_state <= R_WAIT;
            r_cnt   <= RLAT;
          end
        end
        R_WAIT: if (r_cnt == 4'd1) begin
          r_state <= R_DATA;
          r_cnt   <= '0;
          rvalid  <= 1'b1;
          rdata   <= r_word;
          rresp   <= r_ok ? OKAY : SLVERR;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        R_DATA: if (rready) begin
          r_state <= R_IDLE;
          rvalid  <= 1'b0;
          arready <= 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel; c_* select this-cycle handshake data over latched copies
  w_state_t          w_state;
  logic [IDX_W-1:0]  wr_idx, c_idx;
  logic [DATA_WIDTH-1:0] wr_data, c_data;
  logic [STRB_W-1:0] wr_strb, c_strb;
  logic [3:0]        w_cnt;
  logic              aw_got, w_got, aw_hs, w_hs, aw_next, w_next, c_ok, commit_en;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign aw_next   = aw_got || aw_hs;
  assign w_next    = w_got || w_hs;
  assign c_idx     = aw_hs ? aw_idx : wr_idx;
  assign c_data    = w_hs ? wdata : wr_data;
  assign c_strb    = w_hs ? wstrb : wr_strb;
  assign c_ok      = in_range(c_idx);
  assign commit_en = ((w_state == W_IDLE) && aw_next && w_next && (WLAT == 4'd0)) ||
                     ((w_state == W_WAIT) && (w_cnt == 4'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      wr_idx  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      w_cnt   <= '0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) wr_idx <= aw_idx;
          if (w_hs) begin
            wr_data <= wdata;
            wr_strb <= wstrb;
          end
          aw_got  <= aw_next;
          w_got   <= w_next;
          awready <= !aw_next;
          wready  <= !w_next;
          if (aw_next && w_next) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            if (WLAT == 4'd0) begin
              w_state <= W_RESP;
              aw_got  <= 1'b0;
              w_got   <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= c_ok ? OKAY : SLVERR;
            end else begin
              w_state <= W_WAIT;
              w_cnt   <= WLAT;
            end
          end
        end
        W_WAIT: if (w_cnt == 4'd1) begin
          w_state <= W_RESP;
          w_cnt   <= '0;
          aw_got  <= 1'b0;
          w_got   <= 1'b0;
          bvalid  <= 1'b1;
          bresp   <= c_ok ? OKAY : SLVERR;
        end else begin
          w_cnt <= w_cnt - 4'd1;
        end
        W_RESP: if (bready) begin
          w_state <= W_IDLE;
          bvalid  <= 1'b0;
          awready <= 1'b1;
          wready  <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage is not reset; the read capture above sees the pre-commit word
  always_ff @(posedge clk) begin
    if (commit_en && c_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (c_strb[i]) mem[c_idx[MEM_AW-1:0]][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// tb/tb_axi4lite_mem_slave.sv - directed bench for axi4lite_mem_slave (zero and non-zero latency)
module tb_axi4lite_mem_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;

  logic [31:0] l_awaddr, l_wdata, l_araddr, l_rdata;
  logic [3:0]  l_wstrb;
  logic [1:0]  l_bresp, l_rresp;
  logic l_awvalid, l_awready, l_wvalid, l_wready, l_bvalid, l_bready;
  logic l_arvalid, l_arready, l_rvalid, l_rready;

  int n_checks = 0;
  int n_fail = 0;

  axi4lite_mem_slave dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  axi4lite_mem_slave #(.READ_LATENCY(3), .WRITE_LATENCY(2)) dut_lat (
    .clk(clk), .reset(reset),
    .awaddr(l_awaddr), .awvalid(l_awvalid), .awready(l_awready),
    .wdata(l_wdata), .wstrb(l_wstrb), .wvalid(l_wvalid), .wready(l_wready),
    .bresp(l_bresp), .bvalid(l_bvalid), .bready(l_bready),
    .araddr(l_araddr), .arvalid(l_arvalid), .arready(l_arready),
    .rdata(l_rdata), .rresp(l_rresp), .rvalid(l_rvalid), .rready(l_rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write0(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        output logic [1:0] resp, output int lat);
    logic aw_done, w_done;
    int guard;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    guard = 0;
    while ((awvalid || wvalid) && guard < 20) begin
      aw_done = awvalid && awready;
      w_done  = wvalid && wready;
      tick();
      guard++;
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic read0(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                       output int lat);
    int guard;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    guard = 0;
    while (!arready && guard < 20) begin tick(); guard++; end
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    data = rdata; resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    n_checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1)
      begin n_fail++; $display("FAIL reset_ready_during: got %b%b%b expected 111", arready, awready, wready); end
    tick(); tick();
    reset = 1'b1;
    n_checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1)
      begin n_fail++; $display("FAIL reset_ready_after: got %b%b%b expected 111", arready, awready, wready); end
    n_checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0)
      begin n_fail++; $display("FAIL reset_valid: got rvalid=%b bvalid=%b expected 0 0", rvalid, bvalid); end
    n_checks++;
    if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00)
      begin n_fail++; $display("FAIL reset_data: got rdata=%h rresp=%b bresp=%b expected 0", rdata, rresp, bresp); end
    n_checks++;
    if (l_arready !== 1'b1 || l_rvalid !== 1'b0 || l_bvalid !== 1'b0)
      begin n_fail++; $display("FAIL reset_lat_dut: got arready=%b rvalid=%b bvalid=%b", l_arready, l_rvalid, l_bvalid); end
    tick();
  endtask

  task automatic test_single_word();
    logic [1:0] resp; logic [31:0] data; int lat;
    write0(32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
    n_checks++;
    if (resp !== 2'b00 || lat !== 0)
      begin n_fail++; $display("FAIL single_bresp: got resp=%b lat=%0d expected 00 0", resp, lat); end
    read0(32'h10, data, resp, lat);
    n_checks++;
    if (data !== 32'hDEADBEEF || resp !== 2'b00)
      begin n_fail++; $display("FAIL single_rdata: got %h/%b expected deadbeef/00", data, resp); end
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL single_rlat: got %0d expected 0", lat); end
    read0(32'h13, data, resp, lat);
    n_checks++;
    if (data !== 32'hDEADBEEF || resp !== 2'b00)
      begin n_fail++; $display("FAIL unaligned_read: got %h/%b expected deadbeef/00", data, resp); end
  endtask

  task automatic test_strobe_order();
    logic [1:0] resp; logic [31:0] data; int lat;
    write0(32'h20, 32'h11223344, 4'hF, resp, lat);
    wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (bvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b1)
        begin n_fail++; $display("FAIL order_wait%0d: got bvalid=%b wready=%b awready=%b expected 0 0 1", k, bvalid, wready, awready); end
      if (k == 3) begin awaddr = 32'h20; awvalid = 1'b1; end
      tick();
    end
    awvalid = 1'b0;
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00)
      begin n_fail++; $display("FAIL order_bvalid: got %b/%b expected 1/00", bvalid, bresp); end
    tick();
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL order_single_b: got bvalid=%b expected 0", bvalid); end
    read0(32'h20, data, resp, lat);
    n_checks++;
    if (data !== 32'h11BB33DD) begin n_fail++; $display("FAIL strobe_merge: got %h expected 11bb33dd", data); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] data; int lat;
    write0(32'h0, 32'h0BADC0DE, 4'hF, resp, lat);
    write0(32'h1000, 32'hCAFEF00D, 4'hF, resp, lat);
    n_checks++;
    if (resp !== 2'b10) begin n_fail++; $display("FAIL oor_bresp: got %b expected 10", resp); end
    read0(32'h0, data, resp, lat);
    n_checks++;
    if (data !== 32'h0BADC0DE) begin n_fail++; $display("FAIL oor_no_alias: got %h expected 0badc0de", data); end
    read0(32'h1000, data, resp, lat);
    n_checks++;
    if (data !== 32'h0 || resp !== 2'b10)
      begin n_fail++; $display("FAIL oor_read: got %h/%b expected 0/10", data, resp); end
    write0(32'hFFC, 32'h600DCAFE, 4'hF, resp, lat);
    read0(32'hFFC, data, resp, lat);
    n_checks++;
    if (data !== 32'h600DCAFE || resp !== 2'b00)
      begin n_fail++; $display("FAIL last_word: got %h/%b expected 600dcafe/00", data, resp); end
  endtask

  task automatic test_concurrency();
    logic [1:0] resp; logic [31:0] data; int lat;
    write0(32'h30, 32'h01010101, 4'hF, resp, lat);
    araddr = 32'h30; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h30; awvalid = 1'b1; wdata = 32'h02020202; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1)
      begin n_fail++; $display("FAIL conc_valids: got rvalid=%b bvalid=%b expected 1 1", rvalid, bvalid); end
    n_checks++;
    if (rdata !== 32'h01010101) begin n_fail++; $display("FAIL conc_old_data: got %h expected 01010101", rdata); end
    tick();
    rready = 1'b0; bready = 1'b0;
    read0(32'h30, data, resp, lat);
    n_checks++;
    if (data !== 32'h02020202) begin n_fail++; $display("FAIL conc_new_data: got %h expected 02020202", data); end
  endtask

  task automatic test_latency_backpressure();
    int r_first, b_first;
    l_awaddr = 32'h40; l_wdata = 32'h5A5A5A5A; l_wstrb = 4'hF; l_araddr = 32'h40;
    l_awvalid = 1'b1; l_wvalid = 1'b1; l_arvalid = 1'b1; l_rready = 1'b0; l_bready = 1'b0;
    n_checks++;
    if (l_awready !== 1'b1 || l_wready !== 1'b1 || l_arready !== 1'b1)
      begin n_fail++; $display("FAIL lat_idle_ready: got %b%b%b expected 111", l_awready, l_wready, l_arready); end
    tick();
    l_awvalid = 1'b0; l_wvalid = 1'b0; l_arvalid = 1'b0;
    r_first = 0; b_first = 0;
    for (int k = 1; k <= 9; k++) begin
      if (l_rvalid && r_first == 0) r_first = k;
      if (l_bvalid && b_first == 0) b_first = k;
      n_checks++;
      if (l_arready !== 1'b0 || l_awready !== 1'b0 || l_wready !== 1'b0)
        begin n_fail++; $display("FAIL lat_ready_low%0d: got %b%b%b expected 000", k, l_arready, l_awready, l_wready); end
      if (l_rvalid) begin
        n_checks++;
        if (l_rdata !== 32'h5A5A5A5A || l_rresp !== 2'b00)
          begin n_fail++; $display("FAIL lat_rdata_hold%0d: got %h/%b expected 5a5a5a5a/00", k, l_rdata, l_rresp); end
      end
      if (l_bvalid) begin
        n_checks++;
        if (l_bresp !== 2'b00) begin n_fail++; $display("FAIL lat_bresp_hold%0d: got %b expected 00", k, l_bresp); end
      end
      tick();
    end
    n_checks++;
    if (r_first !== 4) begin n_fail++; $display("FAIL read_latency: got %0d expected 4", r_first); end
    n_checks++;
    if (b_first !== 3) begin n_fail++; $display("FAIL write_latency: got %0d expected 3", b_first); end
    l_rready = 1'b1; l_bready = 1'b1;
    tick();
    l_rready = 1'b0; l_bready = 1'b0;
    n_checks++;
    if (l_rvalid !== 1'b0 || l_bvalid !== 1'b0 || l_arready !== 1'b1 || l_awready !== 1'b1)
      begin n_fail++; $display("FAIL lat_release: got rv=%b bv=%b ar=%b aw=%b expected 0 0 1 1", l_rvalid, l_bvalid, l_arready, l_awready); end
  endtask

  task automatic test_reset_mid_write();
    logic saw_b;
    int lat;
    l_awaddr = 32'h40; l_wdata = 32'hFFFFFFFF; l_wstrb = 4'hF;
    l_awvalid = 1'b1; l_wvalid = 1'b1; l_bready = 1'b1;
    tick();
    l_awvalid = 1'b0; l_wvalid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (l_bvalid !== 1'b0 || l_awready !== 1'b1 || l_wready !== 1'b1)
      begin n_fail++; $display("FAIL rst_async: got bvalid=%b awready=%b wready=%b expected 0 1 1", l_bvalid, l_awready, l_wready); end
    tick(); tick();
    reset = 1'b1;
    n_checks++;
    if (l_arready !== 1'b1 || l_awready !== 1'b1 || l_wready !== 1'b1 || arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1)
      begin n_fail++; $display("FAIL rst_release_ready: got %b%b%b %b%b%b expected 111 111", l_arready, l_awready, l_wready, arready, awready, wready); end
    saw_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (l_bvalid) saw_b = 1'b1;
      tick();
    end
    l_bready = 1'b0;
    n_checks++;
    if (saw_b !== 1'b0) begin n_fail++; $display("FAIL rst_no_bvalid: got bvalid seen=%b expected 0", saw_b); end
    l_araddr = 32'h40; l_arvalid = 1'b1; l_rready = 1'b1;
    tick();
    l_arvalid = 1'b0;
    lat = 0;
    while (!l_rvalid && lat < 20) begin tick(); lat++; end
    n_checks++;
    if (l_rdata !== 32'h5A5A5A5A || lat !== 3)
      begin n_fail++; $display("FAIL rst_word_kept: got %h lat=%0d expected 5a5a5a5a lat=3", l_rdata, lat); end
    tick();
    l_rready = 1'b0;
  endtask

  initial begin
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    l_awaddr = '0; l_awvalid = 1'b0; l_wdata = '0; l_wstrb = '0; l_wvalid = 1'b0; l_bready = 1'b0;
    l_araddr = '0; l_arvalid = 1'b0; l_rready = 1'b0;
    test_reset();
    test_single_word();
    test_strobe_order();
    test_out_of_range();
    test_concurrency();
    test_latency_backpressure();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
